// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
// N-way round-robin signal controller. Each approach has a plate FIFO and an
// adaptive green time driven by its queue length. Phases are separated by an
// all-red clearance. Removals from an approach without green are logged in a
// circular violation log that can be cycled on log_plate one entry per tick.
module traffic_phase_controller #(
  parameter int N_WAYS       = 4,
  parameter int PLATE_W      = 5,
  parameter int QDEPTH       = 32,
  parameter int LOG_DEPTH    = 16,
  parameter int TIME_W       = 7,
  parameter int GREEN_INIT   = 40,
  parameter int REG_MIN      = 40,
  parameter int REG_MAX      = 80,
  parameter int RUSH_MIN     = 30,
  parameter int RUSH_MAX     = 70,
  parameter int STEP         = 5,
  parameter int LOW_TH       = 10,
  parameter int HIGH_TH      = 20,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        tick,
  input  logic                                        rush,
  input  logic                                        add_valid,
  input  logic [$clog2(N_WAYS)-1:0]                   add_way,
  input  logic                                        remove_valid,
  input  logic [$clog2(N_WAYS)-1:0]                   remove_way,
  input  logic [PLATE_W-1:0]                          plate_in,
  input  logic                                        display_en,
  input  logic                                        clear_log,
  output logic [N_WAYS-1:0]                           green,
  output logic [TIME_W-1:0]                           remaining,
  output logic [N_WAYS*($clog2(QDEPTH)+1)-1:0]        count,
  output logic [N_WAYS-1:0]                           q_full,
  output logic                                        drop,
  output logic [$clog2(LOG_DEPTH):0]                  viol_count,
  output logic [PLATE_W-1:0]                          log_plate
);

  localparam int WAY_W = $clog2(N_WAYS);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LOG_W = $clog2(LOG_DEPTH);
  localparam int TW1   = TIME_W + 1;

  localparam logic [CNT_W-1:0]  FULL_C     = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0]  LOW_C      = CNT_W'(LOW_TH);
  localparam logic [CNT_W-1:0]  HIGH_C     = CNT_W'(HIGH_TH);
  localparam logic [TW1-1:0]    STEP_X     = TW1'(STEP);
  localparam logic [TW1-1:0]    REG_MIN_X  = TW1'(REG_MIN);
  localparam logic [TW1-1:0]    REG_MAX_X  = TW1'(REG_MAX);
  localparam logic [TW1-1:0]    RUSH_MIN_X = TW1'(RUSH_MIN);
  localparam logic [TW1-1:0]    RUSH_MAX_X = TW1'(RUSH_MAX);
  localparam logic [TIME_W-1:0] INIT_T     = TIME_W'(GREEN_INIT);
  localparam logic [TIME_W-1:0] ALLRED_T   = TIME_W'(ALLRED_TICKS);
  localparam logic [TIME_W-1:0] ONE_T      = TIME_W'(1);
  localparam logic [LOG_W:0]    LOG_FULL_C = (LOG_W+1)'(LOG_DEPTH);

  // The green-time decrement can only stay non-negative if every lower bound
  // is at least one adjustment step; clearance must last at least one tick.
  if (REG_MIN < STEP || RUSH_MIN < STEP || ALLRED_TICKS < 1) begin : gParamCheck
    $error("traffic_phase_controller: MIN bounds must be >= STEP and ALLRED_TICKS >= 1");
  end

  typedef enum logic {PH_GREEN, PH_ALLRED} phase_t;

  phase_t            state, stateNext;
  logic [WAY_W-1:0]  active, activeNext, nextWay;
  logic [TIME_W-1:0] remainingNext;
  logic [TIME_W-1:0] turnTime [N_WAYS];
  logic [TIME_W-1:0] turnTimeNext [N_WAYS];
  logic [TW1-1:0]    tBase, tAdj, tClamp, minX, maxX;
  logic [N_WAYS-1:0] greenVec;

  logic [CNT_W-1:0]   qCount [N_WAYS];
  logic [PLATE_W-1:0] qHead  [N_WAYS];
  logic [N_WAYS-1:0]  dropHit, remHit;

  logic               violPush, logWrite;
  logic [PLATE_W-1:0] logMem [LOG_DEPTH];
  logic [LOG_W-1:0]   logWr, dispOff, logOldest, logIdx;
  logic [LOG_W:0]     logCnt, dispNext;

  // ---------------------------------------------------------------------------
  // Per-approach plate FIFOs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_WAYS; gi++) begin : gWay
    logic [PLATE_W-1:0] mem [QDEPTH];
    logic [PTR_W-1:0]   rdPtr, wrPtr;
    logic [CNT_W-1:0]   cnt;
    logic               doAdd, doRem, remOk, addOk;

    assign doAdd = add_valid && (add_way == WAY_W'(gi));
    assign doRem = remove_valid && (remove_way == WAY_W'(gi));
    // A remove frees the head slot in the same edge, so a full FIFO can still
    // take an add paired with a remove; an empty one ignores the remove.
    assign remOk = doRem && (cnt != '0);
    assign addOk = doAdd && ((cnt != FULL_C) || remOk);

    // Plate storage: write-only port, head is read from the pre-edge pointer
    always_ff @(posedge clk) begin
      if (addOk) mem[wrPtr] <= plate_in;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdPtr <= '0;
        wrPtr <= '0;
        cnt   <= '0;
      end else begin
        if (addOk) wrPtr <= wrPtr + 1'b1;
        if (remOk) rdPtr <= rdPtr + 1'b1;
        if (addOk && !remOk)      cnt <= cnt + 1'b1;
        else if (remOk && !addOk) cnt <= cnt - 1'b1;
      end
    end

    assign qCount[gi]                 = cnt;
    assign qHead[gi]                  = mem[rdPtr];
    assign dropHit[gi]                = doAdd && !addOk;
    assign remHit[gi]                 = remOk;
    assign q_full[gi]                 = (cnt == FULL_C);
    assign count[gi*CNT_W +: CNT_W]   = cnt;
  end

  // Rejected-add indication, one cycle after the offending add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop <= 1'b0;
    else        drop <= |dropHit;
  end

  // ---------------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------------
  assign greenVec = (state == PH_GREEN) ? (N_WAYS'(1) << active) : '0;
  assign green    = greenVec;

  // Phase state, active approach, countdown and learned green times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PH_GREEN;
      active    <= '0;
      remaining <= INIT_T;
      for (int i = 0; i < N_WAYS; i++) turnTime[i] <= INIT_T;
    end else begin
      state     <= stateNext;
      active    <= activeNext;
      remaining <= remainingNext;
      turnTime  <= turnTimeNext;
    end
  end

  // Next-phase decision: adapt the upcoming approach's green time to its queue
  always_comb begin
    stateNext     = state;
    activeNext    = active;
    remainingNext = remaining;
    turnTimeNext  = turnTime;

    nextWay = (active == WAY_W'(N_WAYS - 1)) ? '0 : active + 1'b1;
    minX    = rush ? RUSH_MIN_X : REG_MIN_X;
    maxX    = rush ? RUSH_MAX_X : REG_MAX_X;
    tBase   = {1'b0, turnTime[nextWay]};

    if (qCount[nextWay] <= LOW_C)       tAdj = tBase + STEP_X;
    else if (qCount[nextWay] >= HIGH_C) tAdj = tBase - STEP_X;
    else                                tAdj = tBase;

    // Clamping every time also pulls a stale value into range after rush flips
    if (tAdj < minX)      tClamp = minX;
    else if (tAdj > maxX) tClamp = maxX;
    else                  tClamp = tAdj;

    if (tick) begin
      if (remaining > ONE_T) begin
        remainingNext = remaining - 1'b1;
      end else if (state == PH_GREEN) begin
        stateNext     = PH_ALLRED;
        remainingNext = ALLRED_T;
      end else begin
        stateNext             = PH_GREEN;
        activeNext            = nextWay;
        turnTimeNext[nextWay] = tClamp[TIME_W-1:0];
        remainingNext         = tClamp[TIME_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Violation log and display
  // ---------------------------------------------------------------------------
  assign violPush = remHit[remove_way] && !greenVec[remove_way];
  assign logWrite = violPush && !clear_log;

  // Log storage: a full log simply overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (logWrite) logMem[logWr] <= qHead[remove_way];
  end

  // Log write pointer and saturating entry count; clear wins over a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logWr  <= '0;
      logCnt <= '0;
    end else if (clear_log) begin
      logWr  <= '0;
      logCnt <= '0;
    end else if (violPush) begin
      logWr <= logWr + 1'b1;
      if (logCnt != LOG_FULL_C) logCnt <= logCnt + 1'b1;
    end
  end

  assign dispNext  = {1'b0, dispOff} + 1'b1;
  assign logOldest = logWr - logCnt[LOG_W-1:0];
  assign logIdx    = logOldest + dispOff;

  // Display offset from the oldest entry; any log change restarts at oldest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispOff <= '0;
    end else if (!display_en || clear_log || violPush) begin
      dispOff <= '0;
    end else if (tick && (logCnt != '0)) begin
      dispOff <= (dispNext == logCnt) ? '0 : dispNext[LOG_W-1:0];
    end
  end

  assign viol_count = logCnt;
  assign log_plate  = (display_en && (logCnt != '0)) ? logMem[logIdx] : '0;

endmodule
